// File: rtl/placement_unload_if.sv
// placement_unload_if
//   Memory read bus (grid, pos_X, pos_Y) and the record output stream of the
//   placement read-back engine.
//   master : the unload engine (drives strobes/addresses and the record)
//   slave  : the memories and the record sink
//   grid_re/grid_addr/grid_dout : grid RAM read port
//   px_*/py_*                   : pos_X / pos_Y RAM read ports
//   o_valid/o_ready             : record handshake
//   o_node/o_x/o_y/o_err        : record fields
interface placement_unload_if;
    logic        grid_re;
    logic [31:0] grid_addr;
    logic [31:0] grid_dout;
    logic        px_re;
    logic [31:0] px_addr;
    logic [31:0] px_dout;
    logic        py_re;
    logic [31:0] py_addr;
    logic [31:0] py_dout;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_node;
    logic [31:0] o_x;
    logic [31:0] o_y;
    logic        o_err;

    modport master (
        output grid_re, grid_addr, px_re, px_addr, py_re, py_addr,
               o_valid, o_node, o_x, o_y, o_err,
        input  grid_dout, px_dout, py_dout, o_ready
    );

    modport slave (
        input  grid_re, grid_addr, px_re, px_addr, py_re, py_addr,
               o_valid, o_node, o_x, o_y, o_err,
        output grid_dout, px_dout, py_dout, o_ready
    );
endinterface

// File: rtl/placement_unload.sv
// placement_unload
//   Scans the N*N grid RAM in row-major order (cell address = x*N + y). Every
//   occupied cell is checked against pos_X/pos_Y of the node it holds, and a
//   (node, x, y, err) record is emitted on a valid/ready stream. Records and
//   error records are counted (saturating) per scan.
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   start                : begin a scan (only looked at in IDLE)
//   busy                 : scan in progress, through the DONE cycle
//   done                 : one-cycle pulse at the end of a scan
//   node_count/err_count : records / error records of the current scan
//   bus                  : memory read ports and record stream (master side)
module placement_unload #(
    parameter int N         = 6,
    parameter int POS_DEPTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               node_count,
    output logic [31:0]               err_count,
    placement_unload_if.master        bus
);
    localparam logic [31:0] EMPTY    = 32'hFFFF_FFFF;
    localparam logic [31:0] NSZ      = 32'(N);
    localparam logic [31:0] LAST     = 32'(N - 1);
    localparam logic [32:0] NODE_LIM = 33'd1 << POS_DEPTH;

    typedef enum logic [3:0] {
        S_IDLE, S_G_RD, S_G_WAIT, S_G_CHK, S_P_RD,
        S_P_WAIT, S_P_CHK, S_EMIT, S_NEXT, S_DONE
    } state_t;

    state_t      r_state, w_state;
    logic [31:0] r_x, w_x;
    logic [31:0] r_y, w_y;
    logic [31:0] r_node, w_node;
    logic        r_err, w_err;
    logic [31:0] r_node_cnt, w_node_cnt;
    logic [31:0] r_err_cnt, w_err_cnt;

    logic        r_busy, r_done;
    logic        r_grid_re, r_p_re;
    logic [31:0] r_grid_addr, r_p_addr;
    logic        r_valid, r_o_err;
    logic [31:0] r_o_node, r_o_x, r_o_y;

    logic        w_oor;
    logic [31:0] w_gaddr;

    // Negative words (EMPTY is filtered first) and ids past the pos RAM depth
    // cannot be looked up, so they become error records without a pos read.
    assign w_oor   = bus.grid_dout[31] || ({1'b0, bus.grid_dout} >= NODE_LIM);
    assign w_gaddr = w_x * NSZ + w_y;

    always_comb begin
        w_state    = r_state;
        w_x        = r_x;
        w_y        = r_y;
        w_node     = r_node;
        w_err      = r_err;
        w_node_cnt = r_node_cnt;
        w_err_cnt  = r_err_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_x        = '0;
                    w_y        = '0;
                    w_node_cnt = '0;
                    w_err_cnt  = '0;
                    w_state    = S_G_RD;
                end
            end
            S_G_RD:   w_state = S_G_WAIT;
            S_G_WAIT: w_state = S_G_CHK;
            S_G_CHK: begin
                w_node = bus.grid_dout;
                if (bus.grid_dout == EMPTY) begin
                    w_state = S_NEXT;
                end else if (w_oor) begin
                    w_err   = 1'b1;
                    w_state = S_EMIT;
                end else begin
                    w_state = S_P_RD;
                end
            end
            S_P_RD:   w_state = S_P_WAIT;
            S_P_WAIT: w_state = S_P_CHK;
            S_P_CHK: begin
                w_err   = (bus.px_dout != r_x) || (bus.py_dout != r_y);
                w_state = S_EMIT;
            end
            S_EMIT: begin
                if (r_valid && bus.o_ready) begin
                    if (r_node_cnt != '1) w_node_cnt = r_node_cnt + 32'd1;
                    if (r_err && (r_err_cnt != '1)) w_err_cnt = r_err_cnt + 32'd1;
                    w_state = S_NEXT;
                end
            end
            S_NEXT: begin
                if (r_y == LAST) begin
                    w_y = '0;
                    w_x = r_x + 32'd1;
                end else begin
                    w_y = r_y + 32'd1;
                end
                w_state = (r_x == LAST && r_y == LAST) ? S_DONE : S_G_RD;
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so that each strobe
    // and flag is high exactly in the cycle its state is current.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_node      <= '0;
            r_err       <= 1'b0;
            r_node_cnt  <= '0;
            r_err_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_grid_re   <= 1'b0;
            r_grid_addr <= '0;
            r_p_re      <= 1'b0;
            r_p_addr    <= '0;
            r_valid     <= 1'b0;
            r_o_node    <= '0;
            r_o_x       <= '0;
            r_o_y       <= '0;
            r_o_err     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_x        <= w_x;
            r_y        <= w_y;
            r_node     <= w_node;
            r_err      <= w_err;
            r_node_cnt <= w_node_cnt;
            r_err_cnt  <= w_err_cnt;
            r_busy     <= (w_state != S_IDLE);
            r_done     <= (w_state == S_DONE);
            r_grid_re  <= (w_state == S_G_RD);
            if (w_state == S_G_RD) r_grid_addr <= w_gaddr;
            r_p_re     <= (w_state == S_P_RD);
            if (w_state == S_P_RD) r_p_addr <= w_node;
            r_valid    <= (w_state == S_EMIT);
            // Fields load once on entering EMIT and hold through any stall.
            if (w_state == S_EMIT && r_state != S_EMIT) begin
                r_o_node <= w_node;
                r_o_x    <= r_x;
                r_o_y    <= r_y;
                r_o_err  <= w_err;
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign node_count    = r_node_cnt;
    assign err_count     = r_err_cnt;
    assign bus.grid_re   = r_grid_re;
    assign bus.grid_addr = r_grid_addr;
    assign bus.px_re     = r_p_re;
    assign bus.py_re     = r_p_re;
    assign bus.px_addr   = r_p_addr;
    assign bus.py_addr   = r_p_addr;
    assign bus.o_valid   = r_valid;
    assign bus.o_node    = r_o_node;
    assign bus.o_x       = r_o_x;
    assign bus.o_y       = r_o_y;
    assign bus.o_err     = r_o_err;
endmodule

// File: tb/tb_placement_unload.sv
module tb_placement_unload;
    localparam int N    = 6;
    localparam int NPOS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done;
    logic [31:0] node_count, err_count;

    placement_unload_if bus();

    placement_unload #(.N(N), .POS_DEPTH(6)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .node_count(node_count), .err_count(err_count), .bus(bus)
    );

    always #5 clk = ~clk;

    int gmem [N*N];
    int posx [NPOS];
    int posy [NPOS];

    // Memories: one-cycle read latency, output held until the next read.
    always @(posedge clk) begin
        if (bus.grid_re) bus.grid_dout <= (bus.grid_addr < N*N) ? gmem[bus.grid_addr] : 32'hDEADBEEF;
        if (bus.px_re)   bus.px_dout   <= (bus.px_addr < NPOS) ? posx[bus.px_addr] : 32'hDEADBEEF;
        if (bus.py_re)   bus.py_dout   <= (bus.py_addr < NPOS) ? posy[bus.py_addr] : 32'hDEADBEEF;
    end

    typedef struct { int node; int x; int y; bit err; } rec_t;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < N*N; i++) gmem[i] = -1;
        for (int i = 0; i < NPOS; i++) begin posx[i] = 7; posy[i] = 7; end
    endtask

    task automatic rand_grid();
        clear_mem();
        for (int i = 0; i < N*N; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r >= 6 && r <= 7) begin
                int nd;
                nd = int'($urandom_range(0, NPOS-1));
                gmem[i] = nd;
                if ($urandom_range(0, 1) == 1) begin posx[nd] = i / N; posy[nd] = i % N; end
                else begin posx[nd] = int'($urandom_range(0, 5)); posy[nd] = int'($urandom_range(0, 5)); end
            end else if (r == 8) begin
                gmem[i] = int'($urandom_range(NPOS, 200));
            end else if (r == 9) begin
                gmem[i] = -int'($urandom_range(2, 100));
            end
        end
    endtask

    // Pulses (or holds) start, follows the scan to its done pulse, checks every
    // record against a reference list derived from the memory contents, and
    // checks the cycle after done. Ends sampling that cycle.
    task automatic run_scan(input string tag, input bit hold, input int stall_fix, output int done_cyc);
        rec_t expq[$];
        rec_t r;
        int e = 0, o = 0, b = 0, s = 0, nerr = 0, nrec, pxs = 0, stall_left = 0;
        bit in_emit = 0;
        for (int x = 0; x < N; x++) begin
            for (int y = 0; y < N; y++) begin
                int v;
                v = gmem[x*N + y];
                if (v == -1) e++;
                else begin
                    r.node = v; r.x = x; r.y = y;
                    if (v < 0 || v >= NPOS) begin b++; r.err = 1; end
                    else begin o++; r.err = (posx[v] != x) || (posy[v] != y); end
                    if (r.err) nerr++;
                    expq.push_back(r);
                end
            end
        end
        nrec = expq.size();
        done_cyc = -1;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        chk({tag, "_first_re"}, bus.grid_re, 1);
        chk({tag, "_first_addr"}, bus.grid_addr, 0);
        chk({tag, "_busy"}, busy, 1);
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (bus.px_re || bus.py_re) pxs++;
            if (bus.o_valid) begin
                if (expq.size() == 0) begin
                    chk({tag, "_extra_rec"}, bus.o_valid, 0);
                    bus.o_ready = 1'b1;
                end else begin
                    if (!in_emit) begin
                        in_emit = 1;
                        stall_left = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
                        s += stall_left;
                    end
                    chk({tag, "_node"}, bus.o_node, expq[0].node);
                    chk({tag, "_x"},    bus.o_x,    expq[0].x);
                    chk({tag, "_y"},    bus.o_y,    expq[0].y);
                    chk({tag, "_err"},  bus.o_err,  expq[0].err);
                    if (stall_left == 0) begin
                        bus.o_ready = 1'b1;
                        void'(expq.pop_front());
                        in_emit = 0;
                    end else begin
                        bus.o_ready = 1'b0;
                        stall_left--;
                    end
                end
            end else begin
                bus.o_ready = 1'($urandom_range(0, 1));
            end
            if (done) begin done_cyc = cyc; break; end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) begin
            chk({tag, "_timeout"}, done, 1);
        end else begin
            chk({tag, "_done_cyc"}, done_cyc, 4*e + 8*o + 5*b + s + 1);
            chk({tag, "_busy_done"}, busy, 1);
            chk({tag, "_node_cnt"}, node_count, nrec);
            chk({tag, "_err_cnt"}, err_count, nerr);
            chk({tag, "_pos_reads"}, pxs, o);
            chk({tag, "_left"}, expq.size(), 0);
        end
        bus.o_ready = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_done_after"}, done, 0);
        chk({tag, "_cnt_hold"}, node_count, nrec);
    endtask

    initial begin
        int dc, npx;
        bit found;
        reset = 1'b1;
        start = 1'b0;
        bus.o_ready = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_gre", bus.grid_re, 0);
        chk("rst_pxre", bus.px_re, 0);
        chk("rst_pyre", bus.py_re, 0);
        chk("rst_gaddr", bus.grid_addr, 0);
        chk("rst_pxaddr", bus.px_addr, 0);
        chk("rst_pyaddr", bus.py_addr, 0);
        chk("rst_node", bus.o_node, 0);
        chk("rst_ox", bus.o_x, 0);
        chk("rst_oy", bus.o_y, 0);
        chk("rst_ncnt", node_count, 0);
        chk("rst_ecnt", err_count, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_stays", busy, 0);

        // Empty grid
        run_scan("empty", 0, 0, dc);
        chk("empty_done145", dc, 145);

        // One correctly placed node
        clear_mem();
        gmem[7] = 3; posx[3] = 1; posy[3] = 1;
        run_scan("one_ok", 0, 0, dc);
        chk("one_ok_done149", dc, 149);

        // Same node, wrong y
        posy[3] = 4;
        run_scan("one_bad", 0, 0, dc);
        chk("one_bad_done149", dc, 149);

        // Out-of-range id in the last cell
        clear_mem();
        gmem[35] = 70;
        run_scan("oor", 0, 0, dc);
        chk("oor_done146", dc, 146);

        // Two occupied cells, 10-cycle stall at each record
        clear_mem();
        gmem[4] = 12; posx[12] = 0; posy[12] = 4;
        gmem[30] = 40; posx[40] = 2; posy[40] = 2;
        run_scan("stall", 0, 10, dc);
        chk("stall_done173", dc, 173);

        // Randomized grids and stalls
        for (int t = 0; t < 3; t++) begin
            rand_grid();
            run_scan("rand", 0, -1, dc);
        end

        // Reset while waiting on the second pos read
        clear_mem();
        gmem[2] = 5;   posx[5] = 0;  posy[5] = 2;
        gmem[10] = 9;  posx[9] = 1;  posy[9] = 4;
        gmem[20] = 11; posx[11] = 3; posy[11] = 2;
        bus.o_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        npx = 0; found = 0;
        for (int c = 0; c < 500; c++) begin
            if (bus.px_re) begin
                npx++;
                if (npx == 2) begin found = 1; break; end
            end
            @(posedge clk); #1;
        end
        chk("rst_mid_found", found, 1);
        @(posedge clk); #1;
        chk("rst_mid_pre_cnt", node_count, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", bus.o_valid, 0);
        chk("rst_mid_ncnt", node_count, 0);
        chk("rst_mid_ecnt", err_count, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_pxre", bus.px_re, 0);
        chk("rst_mid_gaddr", bus.grid_addr, 0);
        reset = 1'b0;
        bus.o_ready = 1'b0;
        run_scan("rescan", 0, -1, dc);

        // start held high across a whole scan, then a back-to-back scan
        rand_grid();
        run_scan("hold", 1, -1, dc);
        run_scan("after_hold", 0, -1, dc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
